// File: rtl/store_buffer_fwd.sv
// Post-commit store buffer with byte-granular store-to-load forwarding.
// Optional same-word store merging into the youngest entry: define STORE_BUF_COALESCE_EN.
module store_buffer_fwd #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [5:0]       st_instr_id,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic             ld_valid,
    input  logic [5:0]       ld_instr_id,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    output logic             ld_stall,
    output logic [31:0]      ld_fwd_data,
    output logic             mem_wr_valid,
    input  logic             mem_wr_ready,
    output logic [31:0]      mem_wr_addr,
    output logic [31:0]      mem_wr_data,
    output logic [3:0]       mem_wr_strb,
    output logic [CNT_W-1:0] sb_count,
    output logic             sb_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [5:0] INSTR_LB  = 6'd0;
    localparam logic [5:0] INSTR_LH  = 6'd1;
    localparam logic [5:0] INSTR_LW  = 6'd2;
    localparam logic [5:0] INSTR_LBU = 6'd3;
    localparam logic [5:0] INSTR_LHU = 6'd4;
    localparam logic [5:0] INSTR_SB  = 6'd5;
    localparam logic [5:0] INSTR_SH  = 6'd6;
    localparam logic [5:0] INSTR_SW  = 6'd7;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [29:0]      waddr_q [DEPTH];
    logic [29:0]      waddr_d [DEPTH];
    logic [3:0]       strb_q  [DEPTH];
    logic [3:0]       strb_d  [DEPTH];
    logic [31:0]      data_q  [DEPTH];
    logic [31:0]      data_d  [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        full, empty, pop, acc, push, merge_ok, st_is;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && mem_wr_ready;

    // Stores are lane-replicated so the strobe alone selects the live bytes.
    always_comb begin
        st_is    = (st_instr_id == INSTR_SB) || (st_instr_id == INSTR_SH) ||
                   (st_instr_id == INSTR_SW);
        st_strb  = 4'b1111;
        st_wdata = st_data;
        case (st_instr_id)
            INSTR_SB: begin
                st_strb  = 4'b0001 << st_addr[1:0];
                st_wdata = {4{st_data[7:0]}};
            end
            INSTR_SH: begin
                st_strb  = st_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef STORE_BUF_COALESCE_EN
    logic [PTR_W-1:0] young_idx;
    assign young_idx = tail_q - PTR_W'(1);
    // A head leaving this cycle cannot absorb the store; it gets a fresh entry.
    assign merge_ok  = !empty && (waddr_q[young_idx] == st_addr[31:2]) &&
                       !(pop && (young_idx == head_q));
`else
    assign merge_ok  = 1'b0;
`endif

    assign st_ready = !full || merge_ok;
    assign acc      = st_valid && st_is && st_ready;
    assign push     = acc && !merge_ok;

    always_comb begin
        valid_d = valid_q;
        waddr_d = waddr_q;
        strb_d  = strb_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
`ifdef STORE_BUF_COALESCE_EN
        if (acc && merge_ok) begin
            strb_d[young_idx] = strb_q[young_idx] | st_strb;
            for (int b = 0; b < 4; b++)
                if (st_strb[b]) data_d[young_idx][8*b +: 8] = st_wdata[8*b +: 8];
        end
`endif
        if (push) begin
            valid_d[tail_q] = 1'b1;
            waddr_d[tail_q] = st_addr[31:2];
            strb_d[tail_q]  = st_strb;
            data_d[tail_q]  = st_wdata;
            tail_d          = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= '0;
                strb_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            waddr_q <= waddr_d;
            strb_q  <= strb_d;
            data_q  <= data_d;
        end
    end

    assign sb_count     = count_q;
    assign sb_empty     = empty;
    assign mem_wr_valid = !empty;
    assign mem_wr_addr  = mem_wr_valid ? {waddr_q[head_q], 2'b00} : '0;
    assign mem_wr_data  = mem_wr_valid ? data_q[head_q] : '0;
    assign mem_wr_strb  = mem_wr_valid ? strb_q[head_q] : '0;

    logic             ld_is, full_cov;
    logic [3:0]       need, cov;
    logic [31:0]      asm_w, sh_w;
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so younger entries overwrite older lanes.
    always_comb begin
        ld_is = 1'b1;
        need  = 4'b0000;
        case (ld_instr_id)
            INSTR_LB, INSTR_LBU: need = 4'b0001 << ld_addr[1:0];
            INSTR_LH, INSTR_LHU: need = ld_addr[1] ? 4'b1100 : 4'b0011;
            INSTR_LW:            need = 4'b1111;
            default:             ld_is = 1'b0;
        endcase
        ld_is = ld_is && ld_valid;
        cov   = '0;
        asm_w = '0;
        idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (valid_q[idx] && (waddr_q[idx] == ld_addr[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb_q[idx][b]) begin
                        cov[b]           = 1'b1;
                        asm_w[8*b +: 8]  = data_q[idx][8*b +: 8];
                    end
                end
            end
        end
        sh_w     = asm_w >> {ld_addr[1:0], 3'b000};
        full_cov = ((cov & need) == need);
        ld_hit   = ld_is && full_cov;
        ld_stall = ld_is && |(cov & need) && !full_cov;
        ld_fwd_data = '0;
        if (ld_hit) begin
            case (ld_instr_id)
                INSTR_LB:  ld_fwd_data = {{24{sh_w[7]}}, sh_w[7:0]};
                INSTR_LBU: ld_fwd_data = {24'd0, sh_w[7:0]};
                INSTR_LH:  ld_fwd_data = {{16{sh_w[15]}}, sh_w[15:0]};
                INSTR_LHU: ld_fwd_data = {16'd0, sh_w[15:0]};
                default:   ld_fwd_data = sh_w;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer_fwd.sv
// Bench for store_buffer_fwd: queue-based reference model checked every cycle plus directed literals.
module tb_store_buffer_fwd;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam logic [5:0] LB = 6'd0, LH = 6'd1, LW = 6'd2, LBU = 6'd3, LHU = 6'd4;
    localparam logic [5:0] SB = 6'd5, SH = 6'd6, SW = 6'd7;

    logic clk = 1'b0, rst_n = 1'b0;
    logic st_valid = 1'b0, ld_valid = 1'b0, mem_wr_ready = 1'b0;
    logic [5:0] st_instr_id = '0, ld_instr_id = '0;
    logic [31:0] st_addr = '0, st_data = '0, ld_addr = '0;
    logic st_ready, ld_hit, ld_stall, mem_wr_valid, sb_empty;
    logic [31:0] ld_fwd_data, mem_wr_addr, mem_wr_data;
    logic [3:0] mem_wr_strb;
    logic [CNT_W-1:0] sb_count;

    int tests = 0, fails = 0;

    store_buffer_fwd #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_instr_id(st_instr_id),
        .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_instr_id(ld_instr_id), .ld_addr(ld_addr),
        .ld_hit(ld_hit), .ld_stall(ld_stall), .ld_fwd_data(ld_fwd_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb),
        .sb_count(sb_count), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one queue element per buffered store, oldest at index 0.
    typedef struct {
        logic [29:0] waddr;
        logic [3:0]  strb;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];

    function automatic logic is_st(input logic [5:0] id);
        return (id == SB) || (id == SH) || (id == SW);
    endfunction

    function automatic logic m_merge_ok();
`ifdef STORE_BUF_COALESCE_EN
        if (q.size() == 0) return 1'b0;
        if (q[q.size()-1].waddr != st_addr[31:2]) return 1'b0;
        if (q.size() == 1 && mem_wr_ready) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_st_ready();
        return (q.size() < DEPTH) || m_merge_ok();
    endfunction

    function automatic ent_t m_entry();
        ent_t e;
        int off;
        off = int'(st_addr[1:0]);
        e.waddr = st_addr[31:2];
        e.strb = 4'b0000;
        e.data = 32'd0;
        for (int b = 0; b < 4; b++) begin
            if (st_instr_id == SW || (st_instr_id == SB && b == off) ||
                (st_instr_id == SH && b >= off && b < off + 2)) begin
                e.strb[b] = 1'b1;
            end
        end
        if (st_instr_id == SB) e.data = st_data[7:0] * 32'h01010101;
        else if (st_instr_id == SH) e.data = st_data[15:0] * 32'h00010001;
        else e.data = st_data;
        return e;
    endfunction

    task automatic m_load(output logic hit, output logic stall, output logic [31:0] val);
        int nb, off, got;
        logic [31:0] word;
        hit = 0; stall = 0; val = 0; nb = 0;
        if (!ld_valid) return;
        case (ld_instr_id)
            LB, LBU: nb = 1;
            LH, LHU: nb = 2;
            LW:      nb = 4;
            default: nb = 0;
        endcase
        if (nb == 0) return;
        off = int'(ld_addr[1:0]);
        word = 0; got = 0;
        for (int b = off; b < off + nb; b++) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].waddr == ld_addr[31:2] && q[i].strb[b]) begin
                    word[8*b +: 8] = q[i].data[8*b +: 8];
                    got++;
                    break;
                end
            end
        end
        if (got == nb) begin
            hit = 1;
            word = word >> (8 * off);
            if (nb == 1) val = word % 256;
            else if (nb == 2) val = word % 65536;
            else val = word;
            if (ld_instr_id == LB && val >= 128) val = val - 32'd256;
            if (ld_instr_id == LH && val >= 32768) val = val - 32'd65536;
        end else if (got > 0) begin
            stall = 1;
        end
    endtask

    initial forever begin : model_upd
        ent_t e, y;
        logic acc, pop, mrg;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
        end else begin
            mrg = m_merge_ok();
            acc = st_valid && is_st(st_instr_id) && m_st_ready();
            pop = (q.size() > 0) && mem_wr_ready;
            e = m_entry();
            if (acc && mrg) begin
                y = q[q.size()-1];
                for (int b = 0; b < 4; b++)
                    if (e.strb[b]) y.data[8*b +: 8] = e.data[8*b +: 8];
                y.strb = y.strb | e.strb;
                q[q.size()-1] = y;
            end
            if (pop) void'(q.pop_front());
            if (acc && !mrg) q.push_back(e);
        end
    end

    initial forever begin : compare
        logic h, s;
        logic [31:0] v;
        @(negedge clk);
        if (rst_n) begin
            m_load(h, s, v);
            chk("st_ready", st_ready, m_st_ready());
            chk("sb_count", sb_count, q.size());
            chk("sb_empty", sb_empty, q.size() == 0);
            chk("wr_valid", mem_wr_valid, q.size() != 0);
            chk("wr_addr", mem_wr_addr, q.size() != 0 ? {q[0].waddr, 2'b00} : 32'd0);
            chk("wr_data", mem_wr_data, q.size() != 0 ? q[0].data : 32'd0);
            chk("wr_strb", mem_wr_strb, q.size() != 0 ? q[0].strb : 4'd0);
            chk("ld_hit", ld_hit, h);
            chk("ld_stall", ld_stall, s);
            chk("ld_data", ld_fwd_data, v);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drv_st(input logic [5:0] id, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1; st_instr_id = id; st_addr = a; st_data = d;
    endtask

    task automatic drv_ld(input logic [5:0] id, input logic [31:0] a);
        ld_valid = 1; ld_instr_id = id; ld_addr = a;
    endtask

    task automatic drain();
        int n;
        n = 0;
        st_valid = 0; ld_valid = 0; mem_wr_ready = 1;
        while (sb_empty !== 1'b1 && n < 20) begin tick(); n++; end
        chk("drain_done", sb_empty, 1);
        mem_wr_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst st_ready", st_ready, 1);
        chk("rst sb_empty", sb_empty, 1);
        chk("rst sb_count", sb_count, 0);
        chk("rst wr_valid", mem_wr_valid, 0);
        chk("rst ld_hit", ld_hit, 0);
        @(negedge clk); rst_n = 1;
        tick();

        // Store then load; same-cycle store must not be visible.
        drv_st(SW, 32'h100, 32'hDEADBEEF); drv_ld(LW, 32'h100);
        @(negedge clk); chk("same-cycle invisible", ld_hit, 0);
        tick(); st_valid = 0;
        @(negedge clk);
        chk("LW hit", ld_hit, 1);
        chk("LW data", ld_fwd_data, 32'hDEADBEEF);
        drain();

        // Byte sign/zero extension, partial overlap on a word load.
        tick(); drv_st(SB, 32'h103, 32'h80);
        tick(); st_valid = 0; drv_ld(LB, 32'h103);
        @(negedge clk); chk("LB data", ld_fwd_data, 32'hFFFFFF80);
        tick(); drv_ld(LBU, 32'h103);
        @(negedge clk); chk("LBU data", ld_fwd_data, 32'h00000080);
        tick(); drv_ld(LW, 32'h100);
        @(negedge clk); chk("LW partial stall", ld_stall, 1);
        drain();

        // Youngest wins on overlapping lanes.
        tick(); drv_st(SW, 32'h200, 32'h11223344);
        tick(); drv_st(SB, 32'h201, 32'hAA);
        tick(); st_valid = 0; drv_ld(LW, 32'h200);
        @(negedge clk); chk("youngest LW", ld_fwd_data, 32'h1122AA44);
        tick(); drv_ld(LH, 32'h200);
        @(negedge clk); chk("LH signext", ld_fwd_data, 32'hFFFFAA44);
        tick(); drv_ld(LHU, 32'h202);
        @(negedge clk); chk("LHU upper", ld_fwd_data, 32'h00001122);
        drain();

        // Stall resolves once the covering entry drains.
        tick(); drv_st(SB, 32'h300, 32'h55);
        tick(); st_valid = 0; drv_ld(LW, 32'h300);
        @(negedge clk);
        chk("stall set", ld_stall, 1);
        chk("stall nohit", ld_hit, 0);
        chk("stall strb", mem_wr_strb, 4'b0001);
        tick(); mem_wr_ready = 1;
        tick();
        @(negedge clk);
        chk("stall cleared", ld_stall, 0);
        chk("no hit after pop", ld_hit, 0);
        drain();

        // Fill to capacity, drain in order, reset mid-drain.
        for (int i = 0; i < 4; i++) begin
            tick(); drv_st(SW, 32'h500 + 32'(4 * i), 32'(i + 1));
        end
        tick(); drv_st(SW, 32'h510, 32'h5);
        @(negedge clk);
        chk("full st_ready", st_ready, 0);
        chk("full count", sb_count, 4);
        tick(); st_valid = 0; mem_wr_ready = 1;
        @(negedge clk);
        chk("drain0 addr", mem_wr_addr, 32'h500);
        chk("drain0 strb", mem_wr_strb, 4'b1111);
        tick();
        @(negedge clk); chk("drain1 addr", mem_wr_addr, 32'h504);
        tick();
        mem_wr_ready = 0; rst_n = 0;
        #1;
        chk("midrst wr_valid", mem_wr_valid, 0);
        chk("midrst count", sb_count, 0);
        chk("midrst st_ready", st_ready, 1);
        @(negedge clk); rst_n = 1;

        // Two bytes of one word back to back.
        tick(); drv_st(SB, 32'h400, 32'h01);
        tick(); drv_st(SB, 32'h401, 32'h02);
        tick(); st_valid = 0; drv_ld(LH, 32'h400);
        @(negedge clk);
`ifdef STORE_BUF_COALESCE_EN
        chk("coalesce count", sb_count, 1);
        chk("coalesce strb", mem_wr_strb, 4'b0011);
        chk("coalesce data", mem_wr_data[15:0], 16'h0201);
`else
        chk("nocoalesce count", sb_count, 2);
        chk("nocoalesce strb", mem_wr_strb, 4'b0001);
`endif
        chk("LH across entries", ld_fwd_data, 32'h00000201);
        drain();

        // Non-store ID ignored; SH lane replication; push+pop same cycle.
        tick(); drv_st(LW, 32'h700, 32'h1234);
        tick(); st_valid = 0;
        @(negedge clk); chk("non-store ignored", sb_count, 0);
        tick(); drv_st(SH, 32'h402, 32'hBEEF);
        tick(); st_valid = 0;
        @(negedge clk);
        chk("SH data", mem_wr_data, 32'hBEEFBEEF);
        chk("SH strb", mem_wr_strb, 4'b1100);
        tick(); mem_wr_ready = 1; drv_st(SB, 32'h600, 32'h11);
        tick(); drv_st(SB, 32'h601, 32'h22);
        tick(); st_valid = 0;
        @(negedge clk);
        chk("push+pop count", sb_count, 1);
        chk("pop-suppressed merge strb", mem_wr_strb, 4'b0010);
        drain();

        // Pseudo-random traffic over a small address window.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [5:0] sid, lid;
            tick();
            sid = 6'($urandom_range(5, 8));
            lid = 6'($urandom_range(0, 5));
            a = 32'h800 + 32'($urandom_range(0, 11));
            if (sid == SH) a[0] = 1'b0;
            if (sid == SW) a[1:0] = 2'b00;
            st_valid = ($urandom_range(0, 2) != 0);
            st_instr_id = sid; st_addr = a; st_data = $urandom;
            a = 32'h800 + 32'($urandom_range(0, 11));
            if (lid == LH || lid == LHU) a[0] = 1'b0;
            if (lid == LW) a[1:0] = 2'b00;
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_instr_id = lid; ld_addr = a;
            mem_wr_ready = ($urandom_range(0, 2) == 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
